cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_pkg.sv | 15 +
 rtl/rr_picker.sv | 28 ++
 rtl/cordic_arbiter.sv | 122 ++++++++++++
 tb/tb_cordic_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC request arbiter.
package cordic_pkg;

    localparam int ARG_WIDTH_DEF = 24;
    localparam int TIMEOUT_DEF   = 63;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    localparam int PW = $clog2(N);

    always_comb begin : pick
        int   s;
        logic found;
        grant = '0;
        found = 1'b0;
        s     = 0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            if (!found && req[s[PW-1:0]]) begin
                grant[s[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC unit among N_REQ requesters, one transaction at a time.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ARG_WIDTH = ARG_WIDTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ARG_WIDTH-1:0] req_angle,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [ARG_WIDTH-1:0]       resp_x,
    output logic [ARG_WIDTH-1:0]       resp_y,
    output logic                       resp_err,
    output logic                       cordic_load,
    output logic [ARG_WIDTH-1:0]       cordic_angle,
    input  logic [ARG_WIDTH-1:0]       cordic_x,
    input  logic [ARG_WIDTH-1:0]       cordic_y,
    input  logic                       cordic_done
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 2);

    state_t               state;
    logic [IW-1:0]        prio_ptr;
    logic [CW-1:0]        wait_cnt;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     hs;
    logic [IW-1:0]        hs_id;
    logic [IW-1:0]        next_ptr;
    logic [ARG_WIDTH-1:0] hs_angle;

    rr_picker #(.N(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (prio_ptr),
        .grant (grant)
    );

    // req_ready is a registered offer; the transfer is the valid&ready cycle
    always_comb begin
        hs       = req_valid & req_ready;
        hs_id    = '0;
        hs_angle = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (hs[k]) begin
                hs_id    = IW'(k);
                hs_angle = req_angle[k*ARG_WIDTH +: ARG_WIDTH];
            end
        end
        next_ptr = (hs_id == IW'(N_REQ - 1)) ? '0 : hs_id + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            prio_ptr     <= '0;
            wait_cnt     <= '0;
            req_ready    <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_id      <= '0;
            resp_x       <= '0;
            resp_y       <= '0;
            cordic_load  <= 1'b0;
            cordic_angle <= '0;
        end else begin
            req_ready <= '0;
            unique case (state)
                IDLE: begin
                    if (|hs) begin
                        resp_id      <= hs_id;
                        cordic_angle <= hs_angle;
                        prio_ptr     <= next_ptr;
                        cordic_load  <= 1'b1;
                        state        <= LOAD;
                    end else begin
                        req_ready <= grant;
                    end
                end
                LOAD: begin
                    cordic_load <= 1'b0;
                    state       <= RELEASE;
                end
                RELEASE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cordic_done) begin
                        resp_x     <= cordic_x;
                        resp_y     <= cordic_y;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT)) begin
                        resp_x     <= '0;
                        resp_y     <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural CORDIC stand-in.
module tb_cordic_arbiter;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int TO = 63;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_angle = '0;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_x;
    logic [W-1:0]   resp_y;
    logic           resp_err;
    logic           cordic_load;
    logic [W-1:0]   cordic_angle;
    logic [W-1:0]   cordic_x = '0;
    logic [W-1:0]   cordic_y = '0;
    logic           cordic_done = 1'b0;

    always #5 clk = ~clk;

    cordic_arbiter #(.N_REQ(N), .ARG_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_angle    (req_angle),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_x       (resp_x),
        .resp_y       (resp_y),
        .resp_err     (resp_err),
        .cordic_load  (cordic_load),
        .cordic_angle (cordic_angle),
        .cordic_x     (cordic_x),
        .cordic_y     (cordic_y),
        .cordic_done  (cordic_done)
    );

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           tol;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] req, input int tol);
        logic [W-1:0] d;
        int           s;
        d = act - req;
        s = int'($signed(d));
        if (s < 0) s = -s;
        checks++;
        if (s > tol) begin
            errors++;
            $display("FAIL %s actual %0h required %0h +/- %0d",
                     name, act, req, tol);
        end
    endtask

    task automatic expect_resp(input int id, input logic [W-1:0] x,
                               input logic [W-1:0] y, input int tol,
                               input logic err);
        exp_t e;
        e.id  = 2'(id);
        e.x   = x;
        e.y   = y;
        e.tol = tol;
        e.err = err;
        sb.push_back(e);
    endtask

    // CORDIC stand-in: known angles give fixed near-exact answers,
    // anything else gives an angle-tagged pattern to prove routing.
    logic         no_done = 1'b0;
    logic         busy    = 1'b0;
    logic         load_q  = 1'b0;
    logic [W-1:0] ang_l   = '0;
    int           lat     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            busy        = 1'b0;
            load_q      = 1'b0;
            cordic_done = 1'b0;
        end else begin
            cordic_done = 1'b0;
            if (busy) begin
                if (lat == 0) begin
                    busy        = 1'b0;
                    cordic_done = 1'b1;
                    if (ang_l == 24'h000000) begin
                        cordic_x = 24'h0FFFFF;
                        cordic_y = 24'h000001;
                    end else if (ang_l == 24'h0C90FE) begin
                        cordic_x = 24'h0B504D;
                        cordic_y = 24'h0B5051;
                    end else begin
                        cordic_x = ang_l + 24'h000100;
                        cordic_y = ~ang_l;
                    end
                end else begin
                    lat--;
                end
            end
            if (cordic_load && !load_q && !no_done) begin
                busy  = 1'b1;
                lat   = 3;
                ang_l = cordic_angle;
            end
            load_q = cordic_load;
        end
    end

    // Requesters: each holds valid until its valid&ready edge.
    logic [W-1:0] tab[N][8];
    int           head[N] = '{default: 0};
    int           tail[N] = '{default: 0};
    logic [N-1:0] taken   = '0;

    task automatic add_req(input int k, input logic [W-1:0] a);
        tab[k][tail[k]] = a;
        tail[k]++;
    endtask

    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (taken[k]) begin
                head[k]++;
                taken[k] = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (head[k] < tail[k]);
            req_angle[k*W +: W] = req_valid[k] ? tab[k][head[k]] : '0;
        end
        for (int k = 0; k < N; k++) begin
            if (req_valid[k] && req_ready[k]) taken[k] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual id %0d required none",
                         resp_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_err", 32'(resp_err), 32'(e.err));
                check_tol("resp_x", resp_x, e.x, e.tol);
                check_tol("resp_y", resp_y, e.y, e.tol);
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        check(name, 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_load();
        for (int i = 0; i < 200 && !cordic_load; i++) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_x", 32'(resp_x), 32'd0);
        check("rst_resp_y", 32'(resp_y), 32'd0);
        check("rst_cordic_load", 32'(cordic_load), 32'd0);
        check("rst_cordic_angle", 32'(cordic_angle), 32'd0);
        rst = 1'b1;

        @(negedge clk);
        expect_resp(1, 24'h100000, 24'h000000, 2, 1'b0);
        add_req(1, 24'h000000);
        wait_drain("single_drain", 300);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        expect_resp(0, 24'h010100, 24'hFEFFFF, 0, 1'b0);
        expect_resp(1, 24'h020100, 24'hFDFFFF, 0, 1'b0);
        expect_resp(2, 24'h030100, 24'hFCFFFF, 0, 1'b0);
        expect_resp(3, 24'h040100, 24'hFBFFFF, 0, 1'b0);
        expect_resp(0, 24'h050100, 24'hFAFFFF, 0, 1'b0);
        add_req(0, 24'h010000);
        add_req(0, 24'h050000);
        add_req(1, 24'h020000);
        add_req(2, 24'h030000);
        add_req(3, 24'h040000);
        wait_drain("rr_drain", 1000);

        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        expect_resp(2, 24'h020100, 24'hFDFFFF, 0, 1'b0);
        expect_resp(0, 24'h050100, 24'hFAFFFF, 0, 1'b0);
        add_req(2, 24'h020000);
        add_req(0, 24'h050000);
        for (int i = 0; i < 200 && !resp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (!(resp_valid === 1'b1 && resp_id === 2'd2 &&
                  resp_x === 24'h020100 && resp_y === 24'hFDFFFF &&
                  resp_err === 1'b0 && req_ready === 4'b0000)) begin
                errors++;
                $display("FAIL hold cyc %0d actual v%0b id%0d x%0h y%0h rdy%0b required v1 id2 x020100 yfdffff rdy0",
                         i, resp_valid, resp_id, resp_x, resp_y, req_ready);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_drain("hold_drain", 400);

        no_done = 1'b1;
        expect_resp(1, 24'h000000, 24'h000000, 0, 1'b1);
        add_req(1, 24'h030000);
        wait_load();
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TO + 3));
        wait_drain("timeout_drain", 50);

        add_req(3, 24'h040000);
        wait_load();
        repeat (6) @(negedge clk);
        check("angle_held", 32'(cordic_angle), 32'h040000);
        #2 rst = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_resp_err", 32'(resp_err), 32'd0);
        check("arst_resp_id", 32'(resp_id), 32'd0);
        check("arst_cordic_load", 32'(cordic_load), 32'd0);
        check("arst_cordic_angle", 32'(cordic_angle), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        no_done = 1'b0;
        @(negedge clk);
        expect_resp(0, 24'h100000, 24'h000000, 2, 1'b0);
        add_req(0, 24'h000000);
        wait_drain("post_reset_drain", 300);

        @(negedge clk);
        expect_resp(3, 24'h0B504F, 24'h0B504F, 4, 1'b0);
        add_req(3, 24'h0C90FE);
        wait_drain("pi4_drain", 300);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
